speck32_decrypt: RTL and testbench
==================================

SPECK32_DECRYPT -- requirements
Module: speck32_decrypt

Interface
REQ-001 SHALL have parameter ROUNDS, default 22, number of SPECK32/64 rounds; legal range 2..22.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  ciphertext/key offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a new job.
REQ-006 SHALL have port din  input  32  ciphertext {left[31:16], right[15:0]}.
REQ-007 SHALL have port key  input  64  master key {l2[63:48], l1[47:32], l0[31:16], k0[15:0]}.
REQ-008 SHALL have port out_valid  output  1  plaintext available on dout.
REQ-009 SHALL have port out_ready  input  1  consumer takes dout.
REQ-010 SHALL have port dout  output  32  plaintext {left, right}.

Function
REQ-011 SHALL implement FSM states IDLE, EXPAND, DECRYPT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 SHALL accept a job on an edge with in_valid && in_ready: register din into state {x,y}; key words into l-pipeline; write k0 to keyfile[0]; go to EXPAND with i = 0.
REQ-013 SHALL in EXPAND, per edge, compute l_new = (ror(l_i,7) + k_i) ^ i (16-bit, mod 2^16), k_next = rol(k_i,2) ^ l_new, write keyfile[i+1] = k_next, shift l-pipeline, increment i.
REQ-014 SHALL leave EXPAND after writing keyfile[ROUNDS-1] (ROUNDS-1 edges) and enter DECRYPT with round index r = ROUNDS-1.
REQ-015 SHALL in DECRYPT, per edge, apply inverse round with k = keyfile[r]: y' = ror(x ^ y, 2); x' = rol((x ^ k) - y', 7) (subtraction mod 2^16, borrow discarded); decrement r.
REQ-016 SHALL enter DONE on the edge that applies round r = 0; total latency from accepting edge to out_valid high is 2*ROUNDS-1 edges (43 for ROUNDS=22).
REQ-017 SHALL drive dout = {x,y} in DONE and hold it stable while out_valid && !out_ready.
REQ-018 SHALL return DONE -> IDLE on the edge with out_ready high; in_ready rises the following cycle (no accept in the DONE cycle).
REQ-019 SHALL ignore in_valid, din and key outside IDLE; changes to them mid-job SHALL NOT affect the result.
REQ-020 SHALL drive dout = 0 in all states other than DONE.

Reset
REQ-021 SHALL on rst high at any edge, including mid-EXPAND/DECRYPT/DONE, go to IDLE and abort the job, with in_ready = 1, out_valid = 0, dout = 0, i = 0, r = 0 the next cycle.
REQ-022 SHALL give rst priority over any simultaneous handshake; an in_valid on the reset edge is not accepted.
REQ-023 SHALL NOT require keyfile contents to be reset; they are fully rewritten before use.

Structure
REQ-024 SHALL place WORD = 16, ALPHA = 7, BETA = 2, default ROUNDS = 22 and the FSM state enum in shared package speck32_pkg.
REQ-025 SHALL put the combinational inverse round (inputs {x,y} 32b, k 16b; output 32b) in sub-module speck32_dec_round.
REQ-026 SHALL implement the key file as a ROUNDS x 16-bit register array with one write and one read port.

Verification
REQ-027 SHALL test: key 0x1918111009080100, din 0xa86842f2 -> dout 0x6574694c, out_valid exactly 43 edges after accept.
REQ-028 SHALL test: out_ready held low 10 cycles after out_valid -> dout stays 0x6574694c, in_ready stays 0, then IDLE one edge after out_ready.
REQ-029 SHALL test: rst pulsed at edge 20 of a job -> next cycle in_ready = 1, out_valid = 0, dout = 0; new job with REQ-027 vector yields 0x6574694c.
REQ-030 SHALL test: din/key toggled randomly during EXPAND and DECRYPT -> result still 0x6574694c.
REQ-031 SHALL test: 1000 random key/plaintext pairs encrypted by reference model then decrypted, back-to-back with out_ready tied high -> every dout equals original plaintext; accepts spaced exactly 45 cycles apart.
REQ-032 SHALL test: in_valid asserted on same edge as rst -> job not accepted, FSM in IDLE.

Source files
------------

// File: rtl/speck32_pkg.sv
// Shared constants, FSM state encoding and rotate helpers for the
// SPECK32/64 decryption block.
package speck32_pkg;

    localparam int WORD           = 16;
    localparam int ALPHA          = 7;
    localparam int BETA           = 2;
    localparam int ROUNDS_DEFAULT = 22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Rotate a word left by a constant amount.
    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WORD - n));
    endfunction

    // Rotate a word right by a constant amount.
    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD - n));
    endfunction

endpackage

// File: rtl/speck32_dec_round.sv
// One combinational SPECK32 inverse round: undoes a single encryption
// round of {x,y} using round key k.
module speck32_dec_round
    import speck32_pkg::*;
(
    input  logic [2*WORD-1:0] blk_in,
    input  logic [WORD-1:0]   k,
    output logic [2*WORD-1:0] blk_out
);

    logic [WORD-1:0] x;
    logic [WORD-1:0] y;
    logic [WORD-1:0] y_prev;
    logic [WORD-1:0] x_prev;

    // Inverse round: recover y first, then x; the subtraction wraps mod 2^16.
    always_comb begin
        x       = blk_in[2*WORD-1:WORD];
        y       = blk_in[WORD-1:0];
        y_prev  = ror(x ^ y, BETA);
        x_prev  = rol((x ^ k) - y_prev, ALPHA);
        blk_out = {x_prev, y_prev};
    end

endmodule

// File: rtl/speck32_decrypt.sv
// SPECK32/64 decryptor. A job first expands the master key into a
// per-round key file (ROUNDS-1 cycles), then walks the rounds backwards
// (ROUNDS cycles) and presents the plaintext until the consumer takes it.
module speck32_decrypt
    import speck32_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   din,
    input  logic [63:0]   key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   dout
);

    localparam int IDX_W = $clog2(ROUNDS);
    typedef logic [IDX_W-1:0] idx_t;

    state_e          state;
    idx_t            i;
    idx_t            r;
    logic [WORD-1:0] x;
    logic [WORD-1:0] y;
    logic [WORD-1:0] l0;
    logic [WORD-1:0] l1;
    logic [WORD-1:0] l2;
    logic [WORD-1:0] k_cur;

    logic [WORD-1:0] keyfile [ROUNDS];

    logic            accept;
    logic            last_expand;
    logic            last_round;
    logic [WORD-1:0] l_new;
    logic [WORD-1:0] k_next;
    logic [WORD-1:0] k_rd;
    logic            kf_we;
    idx_t            kf_addr;
    logic [WORD-1:0] kf_data;
    logic [31:0]     round_out;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign last_expand = (i == idx_t'(ROUNDS - 2));
    assign last_round  = (r == '0);

    // Key schedule step and key-file write port / read port selection.
    always_comb begin
        l_new   = (ror(l0, ALPHA) + k_cur) ^ {{(WORD-IDX_W){1'b0}}, i};
        k_next  = rol(k_cur, BETA) ^ l_new;
        kf_we   = !rst && (accept || (state == EXPAND));
        kf_addr = accept ? '0 : idx_t'(i + 1'b1);
        kf_data = accept ? key[15:0] : k_next;
        k_rd    = keyfile[r];
        dout    = (state == DONE) ? {x, y} : 32'd0;
    end

    speck32_dec_round u_round (
        .blk_in  ({x, y}),
        .k       (k_rd),
        .blk_out (round_out)
    );

    // Round-key storage, one write and one read port.
    // NOTE: the key file has no reset; every entry read by a job is written
    // by that same job's expansion first, so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (kf_we) begin
            keyfile[kf_addr] <= kf_data;
        end
    end

    // Control FSM with the block state and key-schedule pipeline.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            r     <= '0;
            x     <= '0;
            y     <= '0;
            l0    <= '0;
            l1    <= '0;
            l2    <= '0;
            k_cur <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x     <= din[31:16];
                        y     <= din[15:0];
                        k_cur <= key[15:0];
                        l0    <= key[31:16];
                        l1    <= key[47:32];
                        l2    <= key[63:48];
                        i     <= '0;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    l0    <= l1;
                    l1    <= l2;
                    l2    <= l_new;
                    k_cur <= k_next;
                    if (last_expand) begin
                        // Index is not needed past expansion; park it at zero.
                        i     <= '0;
                        r     <= idx_t'(ROUNDS - 1);
                        state <= DECRYPT;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                DECRYPT: begin
                    {x, y} <= round_out;
                    if (last_round) begin
                        state <= DONE;
                    end else begin
                        r <= r - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_speck32_decrypt.sv
// Self-checking bench for speck32_decrypt: known-answer table, stall,
// mid-job reset, input churn, reset/handshake collision and a long
// back-to-back run against an independent encryption model.
module tb_speck32_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_CT  = 32'ha868_42f2;
    localparam logic [31:0] KAT_PT  = 32'h6574_694c;

    typedef struct {
        logic [63:0] key;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];

    speck32_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    // Reference SPECK32/64 encryption, 22 rounds.
    function automatic logic [31:0] speck_enc(input logic [63:0] k64, input logic [31:0] pt);
        logic [15:0] x, y, k, a, b, c, ln;
        x = pt[31:16]; y = pt[15:0];
        k = k64[15:0]; a = k64[31:16]; b = k64[47:32]; c = k64[63:48];
        for (int n = 0; n < 22; n++) begin
            x = (ror16(x, 7) + y) ^ k;
            y = rol16(y, 2) ^ x;
            ln = (ror16(a, 7) + k) ^ 16'(n);
            k  = rol16(k, 2) ^ ln;
            a = b; b = c; c = ln;
        end
        return {x, y};
    endfunction

    // Offer one job, count latency, optionally stall the consumer and churn inputs.
    task automatic run_job(input logic [63:0] k, input logic [31:0] d, input logic [31:0] exp,
                           input string name, input int hold, input bit churn);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check({name, "_ready_before"}, in_ready, 1'b1);
        key = k; din = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({name, "_busy_after_accept"}, in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 200) begin
            if (churn) begin
                key      = {$urandom, $urandom};
                din      = $urandom;
                in_valid = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, n, 43);
        check({name, "_dout"}, dout, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, "_hold_dout"}, dout, exp);
            check({name, "_hold_valid"}, out_valid, 1'b1);
            check({name, "_hold_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_idle_ready"}, in_ready, 1'b1);
        check({name, "_idle_valid"}, out_valid, 1'b0);
        check({name, "_idle_dout"}, dout, 32'd0);
    endtask

    initial begin
        logic [63:0] nk;
        logic [31:0] np;
        logic [31:0] cur_pt;
        int acc_prev, acc_now, n;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0; key = '0;
        tick(); tick(); tick();
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_dout", dout, 32'd0);
        rst = 1'b0;
        tick();

        check("model_kat", speck_enc(KAT_KEY, KAT_PT), KAT_CT);

        vecs[0] = '{key: KAT_KEY, din: KAT_CT, exp: KAT_PT};
        vecs[1] = '{key: 64'h0, din: 32'h0, exp: 32'h0000_0000};
        vecs[2] = '{key: 64'hffff_ffff_ffff_ffff, din: 32'h0, exp: 32'hffff_ffff};
        vecs[3] = '{key: 64'h0123_4567_89ab_cdef, din: 32'h0, exp: 32'hdead_beef};
        for (int v = 1; v < 4; v++) vecs[v].din = speck_enc(vecs[v].key, vecs[v].exp);

        foreach (vecs[v]) run_job(vecs[v].key, vecs[v].din, vecs[v].exp, $sformatf("vec%0d", v), 0, 1'b0);

        // Consumer stalls for 10 cycles.
        run_job(KAT_KEY, KAT_CT, KAT_PT, "stall", 10, 1'b0);

        // Inputs churn throughout expansion and decryption.
        run_job(KAT_KEY, KAT_CT, KAT_PT, "churn", 0, 1'b1);

        // Reset on edge 20 of a job, then a clean job.
        key = KAT_KEY; din = KAT_CT; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int e = 1; e < 20; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_dout", dout, 32'd0);
        run_job(KAT_KEY, KAT_CT, KAT_PT, "after_rst", 0, 1'b0);

        // in_valid coincides with reset: no job starts.
        key = KAT_KEY; din = KAT_CT; in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_collide_ready", in_ready, 1'b1);
        tick(); tick();
        check("rst_collide_still_idle", in_ready, 1'b1);
        check("rst_collide_no_out", out_valid, 1'b0);

        // Back-to-back random jobs with the consumer always ready.
        out_ready = 1'b1;
        nk = {$urandom, $urandom};
        np = $urandom;
        key = nk; din = speck_enc(nk, np); in_valid = 1'b1;
        acc_prev = 0;
        for (int j = 0; j < 1000; j++) begin
            cur_pt = np;
            tick();
            acc_now = cyc;
            check("b2b_accepted", in_ready, 1'b0);
            if (j > 0) check("b2b_spacing", acc_now - acc_prev, 45);
            acc_prev = acc_now;
            if (j < 999) begin
                nk = {$urandom, $urandom};
                np = $urandom;
                key = nk; din = speck_enc(nk, np);
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 100) begin tick(); n++; end
            check("b2b_dout", dout, cur_pt);
            n = 0;
            tick();
            while (!in_ready && n < 10) begin tick(); n++; end
        end
        out_ready = 1'b0;
        tick();
        check("final_idle", in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
